ula_result_stage: RTL and testbench
===================================

// Module: ula_result_stage
// PURPOSE
//  Registered output stage that sits directly downstream of the ULA logic
//  units (and/or/nand/nor/xor). It accepts a 16-bit result, zero flag and
//  opcode under a valid/ready handshake. It buffers up to two results in a
//  skid buffer so that the upstream ULA path is never timing-coupled to the
//  consumer's ready. It also keeps sticky status: zero-seen, flag-consistency
//  error, and a saturating result counter.
// PARAMETERS
//  DATA_W  16  result width; must match ULA out width
//  OP_W    3   opcode tag width carried alongside result
//  CNT_W   8   width of saturating delivered-result counter
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       asynchronous active-high reset
//  in_valid    in   1       upstream result valid
//  in_ready    out  1       stage can accept (registered, = !skid full)
//  in_result   in   DATA_W  ULA result
//  in_zero     in   1       ULA zero flag
//  in_op       in   OP_W    opcode that produced the result
//  out_valid   out  1       head entry valid
//  out_ready   in   1       downstream accepts head entry
//  out_result  out  DATA_W  head result (registered)
//  out_zero    out  1       head zero flag (registered)
//  out_op      out  OP_W    head opcode (registered)
//  clr_sticky  in   1       sync clear of zero_sticky, flag_err, res_count
//  zero_sticky out  1       set when any accepted result had in_zero=1
//  flag_err    out  1       set when accepted in_zero != (in_result==0)
//  res_count   out  CNT_W   number of output handshakes, saturating
// BEHAVIOUR
//  - Reset (async, rst=1): out_valid=0; in_ready=1; out_result=0;
//    out_zero=0; out_op=0; zero_sticky=0; flag_err=0; res_count=0;
//    skid entry invalid. Reset mid-transfer drops all buffered data.
//  - Handshake: in_fire = in_valid & in_ready.
//    out_fire = out_valid & out_ready.
//    Data is sampled only on fire. in_valid may drop without a fire.
//  - Latency: accepted entry appears on out_* the next cycle when empty.
//  - States, encoded by occupancy:
//    EMPTY: in_fire -> ONE (head loaded).
//    ONE: in_fire & out_fire -> ONE (head replaced by new).
//         in_fire & !out_fire -> TWO (new goes to skid).
//         !in_fire & out_fire -> EMPTY.
//    TWO: in_ready=0, so no in_fire is possible.
//         out_fire -> ONE (skid moves to head). Otherwise hold.
//  - Order is strictly FIFO. No entry is dropped or duplicated.
//    out_* are stable while out_valid & !out_ready.
//  - in_ready is a registered signal. It is 0 only in TWO.
//  - Throughput is 1/cycle while out_ready=1.
//  - zero_sticky: set on in_fire & in_zero.
//  - flag_err: set on in_fire & (in_zero != ~|in_result).
//    The flag is forwarded unchanged, even on a mismatch.
//  - res_count: +1 on out_fire. Holds at 2^CNT_W-1 and never wraps.
//  - clr_sticky with a coincident set event in the same cycle: the event
//    wins. Flag ends at 1; res_count ends at 1 if out_fire, else 0.
// TESTING
//  1. Reset, then in 0x00A5/z0/op2, out_ready=1 -> next cycle out 0x00A5,
//     op2, out_valid=1; res_count=1 after the next cycle.
//  2. out_ready=0, push 0x0011 then 0x0022 -> in_ready=0 after 2nd;
//     raise out_ready -> 0x0011 then 0x0022 on consecutive cycles,
//     in_ready=1 again.
//  3. Push 0x0000/z1 -> zero_sticky=1. Push 0x0003/z1 -> flag_err=1 and
//     out_zero=1 delivered unchanged.
//  4. Stream 300 results with out_ready=1 -> res_count=255 (saturated),
//     all data in order.
//  5. clr_sticky in the same cycle as out_fire -> res_count=1. clr alone
//     -> all sticky flags and res_count are 0.
//  6. Assert rst while in TWO -> same cycle: out_valid=0, in_ready=1;
//     no stale data appears after release.

Source files
------------

// File: rtl/ula_result_if.sv
// Handshake bundle between the ULA logic units, the result stage and its consumer.
// The slave side is the result stage; the master side drives results in and drains them out.
interface ula_result_if #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_zero;
  logic [OP_W-1:0]   in_op;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_zero;
  logic [OP_W-1:0]   out_op;

  modport slave (
    input  in_valid, in_result, in_zero, in_op, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_op
  );

  modport master (
    output in_valid, in_result, in_zero, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_op
  );
endinterface

// File: rtl/ula_result_stage.sv
// Two-entry skid-buffered output stage for ULA results with sticky status
// (zero seen, zero-flag inconsistency) and a saturating delivered-result counter.
module ula_result_stage #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  ula_result_if.slave      bus,
  input  logic             clr_sticky,
  output logic             zero_sticky,
  output logic             flag_err,
  output logic [CNT_W-1:0] res_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic [OP_W-1:0]   op;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  occ_e             state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             zero_sticky_q, zero_sticky_d;
  logic             flag_err_q, flag_err_d;
  logic [CNT_W-1:0] res_count_q, res_count_d;

  logic   in_fire, out_fire;
  entry_t in_entry;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;
  assign in_entry = '{result: bus.in_result, zero: bus.in_zero, op: bus.in_op};

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          head_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          head_d = in_entry;
        end else if (in_fire) begin
          skid_d  = in_entry;
          state_d = TWO;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only the drain side can move.
        if (out_fire) begin
          head_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != TWO);
  end

  // A set event in the same cycle as clr_sticky wins over the clear.
  always_comb begin
    zero_sticky_d = (clr_sticky ? 1'b0 : zero_sticky_q) | (in_fire & bus.in_zero);
    flag_err_d    = (clr_sticky ? 1'b0 : flag_err_q)
                  | (in_fire & (bus.in_zero != ~|bus.in_result));
    res_count_d   = clr_sticky ? '0 : res_count_q;
    if (out_fire && res_count_d != CNT_MAX) begin
      res_count_d = res_count_d + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= EMPTY;
      head_q        <= '0;
      skid_q        <= '0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      zero_sticky_q <= 1'b0;
      flag_err_q    <= 1'b0;
      res_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      skid_q        <= skid_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      zero_sticky_q <= zero_sticky_d;
      flag_err_q    <= flag_err_d;
      res_count_q   <= res_count_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = head_q.result;
  assign bus.out_zero   = head_q.zero;
  assign bus.out_op     = head_q.op;
  assign zero_sticky    = zero_sticky_q;
  assign flag_err       = flag_err_q;
  assign res_count      = res_count_q;

endmodule

// File: tb/tb_ula_result_stage.sv
// Randomized and directed bench for ula_result_stage against a queue-based
// reference model; every negative clock edge compares all outputs.
module tb_ula_result_stage;
  localparam int DATA_W = 16;
  localparam int OP_W   = 3;
  localparam int CNT_W  = 8;
  localparam int CMAX   = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_sticky = 1'b0;
  logic zero_sticky, flag_err;
  logic [CNT_W-1:0] res_count;

  ula_result_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

  ula_result_stage #(.DATA_W(DATA_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clr_sticky (clr_sticky),
    .zero_sticky(zero_sticky),
    .flag_err   (flag_err),
    .res_count  (res_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic [OP_W-1:0]   op;
  } ent_t;

  ent_t m_q[$];
  bit   m_zs = 0;
  bit   m_fe = 0;
  int   m_cnt = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_zs  = 0;
      m_fe  = 0;
      m_cnt = 0;
    end else begin
      bit inf, outf;
      ent_t e;
      inf  = bus.in_valid && (m_q.size() < 2);
      outf = (m_q.size() > 0) && bus.out_ready;
      if (clr_sticky) begin
        m_zs = 0; m_fe = 0; m_cnt = 0;
      end
      if (inf && bus.in_zero) m_zs = 1;
      if (inf && (bus.in_zero != (bus.in_result == 0))) m_fe = 1;
      if (outf && m_cnt < CMAX) m_cnt++;
      if (outf) void'(m_q.pop_front());
      if (inf) begin
        e.result = bus.in_result; e.zero = bus.in_zero; e.op = bus.in_op;
        m_q.push_back(e);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("out_valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
    check("in_ready", 32'(bus.in_ready), 32'(m_q.size() < 2));
    check("zero_sticky", 32'(zero_sticky), 32'(m_zs));
    check("flag_err", 32'(flag_err), 32'(m_fe));
    check("res_count", 32'(res_count), 32'(m_cnt));
    if (m_q.size() > 0) begin
      check("out_result", 32'(bus.out_result), 32'(m_q[0].result));
      check("out_zero", 32'(bus.out_zero), 32'(m_q[0].zero));
      check("out_op", 32'(bus.out_op), 32'(m_q[0].op));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [15:0] r, input logic z, input logic [2:0] op);
    bus.in_valid = v; bus.in_result = r; bus.in_zero = z; bus.in_op = op;
  endtask

  initial begin
    drive_in(1'b0, 16'h0, 1'b0, 3'd0);
    bus.out_ready = 1'b0;
    repeat (2) step();
    // reset state
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_result", 32'(bus.out_result), 0);
    check("rst_out_zero", 32'(bus.out_zero), 0);
    check("rst_out_op", 32'(bus.out_op), 0);
    check("rst_counts", {29'd0, zero_sticky, flag_err, 1'b0} | 32'(res_count), 0);
    rst = 1'b0;
    step();

    // 1: single-cycle latency and count
    bus.out_ready = 1'b1;
    drive_in(1'b1, 16'h00A5, 1'b0, 3'd2);
    step();
    drive_in(1'b0, 16'h0, 1'b0, 3'd0);
    check("t1_valid", 32'(bus.out_valid), 1);
    check("t1_result", 32'(bus.out_result), 32'h00A5);
    check("t1_op", 32'(bus.out_op), 2);
    step();
    check("t1_count", 32'(res_count), 1);

    // 2: fill skid, then drain in order
    bus.out_ready = 1'b0;
    drive_in(1'b1, 16'h0011, 1'b0, 3'd1);
    step();
    drive_in(1'b1, 16'h0022, 1'b0, 3'd3);
    step();
    drive_in(1'b0, 16'h0, 1'b0, 3'd0);
    check("t2_full_ready", 32'(bus.in_ready), 0);
    check("t2_hold_result", 32'(bus.out_result), 32'h0011);
    step();
    check("t2_stable_result", 32'(bus.out_result), 32'h0011);
    bus.out_ready = 1'b1;
    step();
    check("t2_second", 32'(bus.out_result), 32'h0022);
    check("t2_ready_back", 32'(bus.in_ready), 1);
    step();
    check("t2_drained", 32'(bus.out_valid), 0);

    // 3: zero sticky and flag error with unchanged forwarding
    drive_in(1'b1, 16'h0000, 1'b1, 3'd4);
    step();
    drive_in(1'b0, 16'h0, 1'b0, 3'd0);
    check("t3_zero_sticky", 32'(zero_sticky), 1);
    check("t3_flag_ok", 32'(flag_err), 0);
    drive_in(1'b1, 16'h0003, 1'b1, 3'd5);
    step();
    drive_in(1'b0, 16'h0, 1'b0, 3'd0);
    check("t3_flag_err", 32'(flag_err), 1);
    check("t3_zero_fwd", 32'(bus.out_zero), 1);
    check("t3_result", 32'(bus.out_result), 32'h0003);
    step();

    // 4: stream 300 results, counter saturates
    for (int i = 0; i < 300; i++) begin
      drive_in(1'b1, 16'(16'h0100 + i), 1'b0, 3'(i));
      step();
    end
    drive_in(1'b0, 16'h0, 1'b0, 3'd0);
    repeat (2) step();
    check("t4_saturated", 32'(res_count), 255);

    // 5: clear coincident with out_fire, then clear alone
    bus.out_ready = 1'b0;
    drive_in(1'b1, 16'h0005, 1'b0, 3'd6);
    step();
    drive_in(1'b0, 16'h0, 1'b0, 3'd0);
    clr_sticky = 1'b1;
    bus.out_ready = 1'b1;
    step();
    clr_sticky = 1'b0;
    check("t5_clr_fire_count", 32'(res_count), 1);
    check("t5_clr_zs", 32'(zero_sticky), 0);
    check("t5_clr_fe", 32'(flag_err), 0);
    step();
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    check("t5_clr_alone", 32'(res_count), 0);

    // 6: reset while full
    bus.out_ready = 1'b0;
    drive_in(1'b1, 16'h0AAA, 1'b0, 3'd1);
    step();
    drive_in(1'b1, 16'h0BBB, 1'b0, 3'd2);
    step();
    drive_in(1'b0, 16'h0, 1'b0, 3'd0);
    check("t6_full", 32'(bus.in_ready), 0);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(bus.out_valid), 0);
    check("t6_rst_ready", 32'(bus.in_ready), 1);
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    check("t6_no_stale", 32'(bus.out_valid), 0);

    // random phase: all checking done by the per-cycle compare
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] r;
      logic z;
      r = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      z = ($urandom_range(0, 7) == 0) ? ~(r == 0) : (r == 0);
      drive_in(1'($urandom_range(0, 3) != 0), r, z, 3'($urandom));
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      clr_sticky = ($urandom_range(0, 40) == 0);
      step();
    end
    drive_in(1'b0, 16'h0, 1'b0, 3'd0);
    clr_sticky = 1'b0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
